// File: rtl/k_sub_cell.sv
// k_sub_cell: digit-serial K-subtract cell recovering A = S - B LSD-first with a registered borrow.
// Optional feature macro KSUB_BORROW_OUT_EN adds borrow_out (word underflow on the out_last beat).
module k_sub_cell #(
   parameter int unsigned DIGIT_W    = 2,
   parameter int unsigned NUM_DIGITS = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_first,
   input  logic               in_last,
   input  logic [DIGIT_W-1:0] sum_d,
   input  logic [DIGIT_W-1:0] b_d,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_first,
   output logic               out_last,
   output logic [DIGIT_W-1:0] a_d,
   output logic               err
`ifdef KSUB_BORROW_OUT_EN
   ,
   output logic               borrow_out
`endif
);

   localparam int unsigned CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_DIGITS - 1);

   typedef enum logic {StIdle, StMid} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               borrow_q, borrow_d;
   logic               err_q, err_d;
   logic               out_valid_q, out_valid_d;
   logic               out_first_q, out_first_d;
   logic               out_last_q, out_last_d;
   logic [DIGIT_W-1:0] res_q, res_d;
   logic               bo_q, bo_d;

   logic               accept;
   logic               eff_first;
   logic               eff_last;
   logic               at_end;
   logic               bin;
   logic [CNT_W-1:0]   idx;
   logic [DIGIT_W:0]   diff;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      borrow_d    = borrow_q;
      err_d       = err_q;
      out_valid_d = out_valid_q;
      out_first_d = out_first_q;
      out_last_d  = out_last_q;
      res_d       = res_q;
      bo_d        = bo_q;

      // A beat arriving in IDLE always opens a word, flagged or not.
      eff_first = in_first || (state_q == StIdle);
      idx       = eff_first ? '0 : cnt_q;
      bin       = eff_first ? 1'b0 : borrow_q;
      diff      = {1'b0, sum_d} - {1'b0, b_d} - {{DIGIT_W{1'b0}}, bin};
      at_end    = (idx == LAST_IDX);
      eff_last  = in_last || at_end;

      if (out_ready) begin
         out_valid_d = 1'b0;
      end

      if (accept) begin
         out_valid_d = 1'b1;
         out_first_d = eff_first;
         out_last_d  = eff_last;
         res_d       = diff[DIGIT_W-1:0];
         bo_d        = eff_last ? diff[DIGIT_W] : 1'b0;
         borrow_d    = diff[DIGIT_W];
         state_d     = eff_last ? StIdle : StMid;
         cnt_d       = eff_last ? '0 : idx + CNT_W'(1);
         if (((state_q == StIdle) && !in_first) || ((state_q == StMid) && in_first) ||
             (in_last != at_end)) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         borrow_q    <= 1'b0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_first_q <= 1'b0;
         out_last_q  <= 1'b0;
         res_q       <= '0;
         bo_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         borrow_q    <= borrow_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
         out_first_q <= out_first_d;
         out_last_q  <= out_last_d;
         res_q       <= res_d;
         bo_q        <= bo_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_first = out_first_q;
   assign out_last  = out_last_q;
   assign a_d       = res_q;
   assign err       = err_q;

`ifdef KSUB_BORROW_OUT_EN
   assign borrow_out = bo_q;
`else
   logic unused_bo;
   assign unused_bo = bo_q;
`endif

endmodule

// File: tb/tb_k_sub_cell.sv
// tb_k_sub_cell: directed bench for k_sub_cell with a word-level arithmetic model and scoreboard.
// Honours KSUB_BORROW_OUT_EN when the design is built with it.
module tb_k_sub_cell;

   localparam int DW = 2;
   localparam int ND = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, in_first, in_last;
   logic [DW-1:0] sum_d, b_d, a_d;
   logic          out_valid, out_ready, out_first, out_last, err;
   logic          borrow_out;

   typedef struct {
      int a;
      bit first;
      bit last;
      bit bo;
   } beat_t;

   beat_t q[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   bit    checking = 1'b0;

   // Model state: word position and borrow kept as plain integers.
   int    m_err, m_in_word, m_idx, m_borrow;
   int    md, midx, mbin;
   bit    mfe, mle;
   beat_t me;

   // Capture of the most recent output word.
   logic [7:0] cap_word;
   int         cap_n, cap_last_n;
   bit         cap_bo;

   always #5 clk = ~clk;

   k_sub_cell #(.DIGIT_W(DW), .NUM_DIGITS(ND)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_first  (in_first),
      .in_last   (in_last),
      .sum_d     (sum_d),
      .b_d       (b_d),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_first (out_first),
      .out_last  (out_last),
      .a_d       (a_d),
      .err       (err)
`ifdef KSUB_BORROW_OUT_EN
      ,
      .borrow_out(borrow_out)
`endif
   );

`ifndef KSUB_BORROW_OUT_EN
   assign borrow_out = 1'b0;
`endif

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         m_err = 0; m_in_word = 0; m_idx = 0; m_borrow = 0;
      end else begin
         if (out_valid && out_ready) begin
            if (q.size() > 0) void'(q.pop_front());
            if (out_first) begin
               cap_word = 8'h00;
               cap_n    = 0;
            end
            if (cap_n < ND) cap_word[2*cap_n +: 2] = a_d;
            cap_n++;
            if (out_last) begin
               cap_last_n = cap_n;
               cap_bo     = borrow_out;
            end
         end
         if (in_valid && in_ready) begin
            mfe  = in_first || (m_in_word == 0);
            if ((m_in_word == 0) && !in_first) m_err = 1;
            if ((m_in_word != 0) && in_first) m_err = 1;
            midx = mfe ? 0 : m_idx;
            mbin = mfe ? 0 : m_borrow;
            md   = int'(sum_d) - int'(b_d) - mbin;
            mle  = in_last || (midx == ND - 1);
            if (in_last != (midx == ND - 1)) m_err = 1;
            me.a     = (md + (1 << (DW + 2))) % (1 << DW);
            me.first = mfe;
            me.last  = mle;
            me.bo    = mle && (md < 0);
            m_borrow  = (md < 0) ? 1 : 0;
            m_in_word = mle ? 0 : 1;
            m_idx     = mle ? 0 : midx + 1;
            q.push_back(me);
         end
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         chk("out_valid", int'(out_valid), int'(q.size() != 0));
         chk("in_ready", int'(in_ready), int'((q.size() == 0) || out_ready));
         chk("err", int'(err), m_err);
         if (out_valid && (q.size() > 0)) begin
            chk("a_d", int'(a_d), q[0].a);
            chk("out_first", int'(out_first), int'(q[0].first));
            chk("out_last", int'(out_last), int'(q[0].last));
`ifdef KSUB_BORROW_OUT_EN
            chk("borrow_out", int'(borrow_out), int'(q[0].bo));
`endif
         end
      end
   end

   task automatic send_beat(input logic [1:0] s, input logic [1:0] b, input logic f,
                            input logic l);
      int n;
      n        = 0;
      sum_d    = s;
      b_d      = b;
      in_first = f;
      in_last  = l;
      in_valid = 1'b1;
      @(posedge clk);
      while (!in_ready && (n < 50)) begin
         n++;
         @(posedge clk);
      end
      if (n >= 50) chk("send_timeout", 0, 1);
      #1;
   endtask

   task automatic send_word(input logic [7:0] s, input logic [7:0] b, input logic [3:0] fm,
                            input logic [3:0] lm);
      for (int i = 0; i < ND; i++) send_beat(s[2*i +: 2], b[2*i +: 2], fm[i], lm[i]);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      sum_d = '0; b_d = '0; out_ready = 1'b1;
      cap_word = 8'h00; cap_n = 0; cap_last_n = 0; cap_bo = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst      = 1'b0;
      checking = 1'b1;

      @(negedge clk);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_err", int'(err), 0);
      chk("reset_a_d", int'(a_d), 0);
      chk("reset_out_first", int'(out_first), 0);
      chk("reset_out_last", int'(out_last), 0);
`ifdef KSUB_BORROW_OUT_EN
      chk("reset_borrow_out", int'(borrow_out), 0);
`endif
      @(posedge clk);
      #1;

      // 0x9C - 0x25 = 0x77
      cap_last_n = 0;
      send_word(8'h9C, 8'h25, 4'b0001, 4'b1000);
      drain();
      chk("word_9c_25", int'(cap_word), 8'h77);
      chk("word_9c_25_last", cap_last_n, 4);
      chk("word_9c_25_err", int'(err), 0);

      // 0x00 - 0x01 underflows to 0xFF
      send_word(8'h00, 8'h01, 4'b0001, 4'b1000);
      drain();
      chk("word_00_01", int'(cap_word), 8'hFF);
`ifdef KSUB_BORROW_OUT_EN
      chk("word_00_01_borrow", int'(cap_bo), 1);
`endif

      // Backpressure for three cycles after digit 1
      send_beat(2'd0, 2'd1, 1'b1, 1'b0);
      send_beat(2'd3, 2'd1, 1'b0, 1'b0);
      out_ready = 1'b0;
      sum_d = 2'd1; b_d = 2'd2; in_first = 1'b0; in_last = 1'b0; in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("stall_in_ready", int'(in_ready), 0);
         chk("stall_out_valid", int'(out_valid), 1);
         chk("stall_a_d", int'(a_d), 1);
         @(posedge clk);
      end
      #1;
      out_ready = 1'b1;
      send_beat(2'd1, 2'd2, 1'b0, 1'b0);
      send_beat(2'd2, 2'd0, 1'b0, 1'b1);
      drain();
      chk("stall_word", int'(cap_word), 8'h77);

      // Unframed start, then restart with in_first at digit 2
      send_beat(2'd0, 2'd1, 1'b0, 1'b0);
      send_beat(2'd0, 2'd1, 1'b0, 1'b0);
      send_word(8'h9C, 8'h25, 4'b0001, 4'b1000);
      drain();
      chk("restart_word", int'(cap_word), 8'h77);
      chk("restart_err", int'(err), 1);
      send_word(8'h00, 8'h01, 4'b0001, 4'b1000);
      drain();
      chk("sticky_word", int'(cap_word), 8'hFF);
      chk("sticky_err", int'(err), 1);

      // Missing in_last: last forced on the fourth beat
      do_reset();
      cap_last_n = 0;
      send_word(8'h9C, 8'h25, 4'b0001, 4'b0000);
      drain();
      chk("forced_last_pos", cap_last_n, 4);
      chk("forced_last_word", int'(cap_word), 8'h77);
      chk("forced_last_err", int'(err), 1);
      cap_last_n = 0;
      send_word(8'h9C, 8'h25, 4'b0001, 4'b1000);
      drain();
      chk("after_forced_word", int'(cap_word), 8'h77);
      chk("after_forced_last", cap_last_n, 4);

      // Reset in mid-word clears err and in-flight state
      do_reset();
      send_beat(2'd0, 2'd1, 1'b0, 1'b0);
      send_beat(2'd3, 2'd1, 1'b0, 1'b0);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midreset_out_valid", int'(out_valid), 0);
      chk("midreset_err", int'(err), 0);
      @(posedge clk);
      #1;
      send_word(8'h9C, 8'h25, 4'b0001, 4'b1000);
      drain();
      chk("midreset_word", int'(cap_word), 8'h77);
      chk("midreset_word_err", int'(err), 0);

      checking = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
